// File: rtl/uart_pkg.sv
// Constants shared between the UART receiver and transmitter: frame width, FSM encodings, bit timing.
// Pure definitions, no logic, no latency.
package uart_pkg;

    localparam int FRAME_BITS = 8;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_START   = 3'd1;
    localparam logic [2:0] S_DATA    = 3'd2;
    localparam logic [2:0] S_STOP    = 3'd3;
    localparam logic [2:0] S_WAIT_HI = 3'd4;

    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_rx_frame_if.sv
// Receive-side bundle: serial line in, byte plus one-cycle strobes out.
// master = receiver; slave = whoever drives the line and consumes bytes.
interface uart_rx_frame_if;
    logic       uart_rxd;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_frame_err;
    logic       rx_busy;

    modport master (
        input  uart_rxd,
        output rx_data, rx_valid, rx_frame_err, rx_busy
    );

    modport slave (
        output uart_rxd,
        input  rx_data, rx_valid, rx_frame_err, rx_busy
    );
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for an asynchronous single-bit input; reset value is a parameter.
// Latency 2 cycles; no backpressure.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/uart_rx_frame.sv
// 8N1 UART receiver: mid-bit sampling, byte with one-cycle valid strobe, framing-error strobe.
// rx_valid ~2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT cycles after the start edge; no backpressure.
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int CLK_HZ = 10_000_000,
    parameter int BAUD   = 9600
) (
    input  logic          clk,
    input  logic          reset_n,
    uart_rx_frame_if.master rx
);
    localparam int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int IDX_W        = $clog2(FRAME_BITS);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BITS - 1);

    logic                  rxd_s;
    logic [2:0]            state;
    logic [CNT_W-1:0]      clk_cnt;
    logic [IDX_W-1:0]      bit_idx;
    logic [FRAME_BITS-1:0] shift;
    logic [7:0]            data_q;
    logic                  valid_q;
    logic                  err_q;

    sync_2ff #(.RST_VAL(1'b1)) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (rx.uart_rxd),
        .q       (rxd_s)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            clk_cnt <= '0;
            bit_idx <= '0;
            shift   <= '0;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!rxd_s) begin
                        state   <= S_START;
                        clk_cnt <= '0;
                    end
                end
                // Re-check the line mid start bit so short low glitches are dropped silently.
                S_START: begin
                    if (clk_cnt == HALF_M1) begin
                        clk_cnt <= '0;
                        bit_idx <= '0;
                        state   <= rxd_s ? S_IDLE : S_DATA;
                    end else begin
                        clk_cnt <= clk_cnt + CNT_W'(1);
                    end
                end
                S_DATA: begin
                    if (clk_cnt == FULL_M1) begin
                        clk_cnt <= '0;
                        shift   <= {rxd_s, shift[FRAME_BITS-1:1]};
                        if (bit_idx == LAST_IDX)
                            state <= S_STOP;
                        else
                            bit_idx <= bit_idx + IDX_W'(1);
                    end else begin
                        clk_cnt <= clk_cnt + CNT_W'(1);
                    end
                end
                S_STOP: begin
                    if (clk_cnt == FULL_M1) begin
                        clk_cnt <= '0;
                        if (rxd_s) begin
                            data_q  <= shift;
                            valid_q <= 1'b1;
                            state   <= S_IDLE;
                        end else begin
                            err_q <= 1'b1;
                            state <= S_WAIT_HI;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CNT_W'(1);
                    end
                end
                // A low stop bit may be a break; wait for the line to recover before re-arming.
                S_WAIT_HI: begin
                    if (rxd_s)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign rx.rx_data      = data_q;
    assign rx.rx_valid     = valid_q;
    assign rx.rx_frame_err = err_q;
    assign rx.rx_busy      = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame at CLKS_PER_BIT = 16.
module tb_uart_rx_frame;
    localparam int CPB = 16;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    uart_rx_frame_if bus ();

    uart_rx_frame #(.CLK_HZ(160_000), .BAUD(10_000)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .rx      (bus)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int valid_cnt   = 0;
    int err_cnt     = 0;
    int both_cnt    = 0;
    int valid_cyc   = 0;
    int start_cyc   = 0;
    logic [7:0] cap [0:15];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.rx_valid) begin
            if (valid_cnt < 16) cap[valid_cnt] = bus.rx_data;
            valid_cnt = valid_cnt + 1;
            valid_cyc = cyc;
        end
        if (bus.rx_frame_err) err_cnt = err_cnt + 1;
        if (bus.rx_valid && bus.rx_frame_err) both_cnt = both_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b, input int n);
        @(negedge clk);
        bus.uart_rxd = b;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] d, input logic stop);
        @(negedge clk);
        bus.uart_rxd = 1'b0;
        start_cyc = cyc;
        repeat (CPB - 1) @(negedge clk);
        for (int i = 0; i < 8; i++) drive_bit(d[i], CPB);
        drive_bit(stop, CPB);
    endtask

    initial begin
        logic [7:0] sum;
        logic [7:0] b5a;
        int lat;

        bus.uart_rxd = 1'b1;
        settle(3);
        chk("reset_data",  {24'h0, bus.rx_data}, 32'h00);
        chk("reset_valid", {31'h0, bus.rx_valid}, 32'h0);
        chk("reset_err",   {31'h0, bus.rx_frame_err}, 32'h0);
        chk("reset_busy",  {31'h0, bus.rx_busy}, 32'h0);
        reset_n = 1'b1;
        settle(4);

        // 1: single good frame
        send(8'hA5, 1'b1);
        settle(2);
        lat = valid_cyc - start_cyc;
        chk("t1_valid_cnt", valid_cnt, 1);
        chk("t1_cap",       {24'h0, cap[0]}, 32'hA5);
        chk("t1_data",      {24'h0, bus.rx_data}, 32'hA5);
        chk("t1_err_cnt",   err_cnt, 0);
        chk("t1_busy",      {31'h0, bus.rx_busy}, 32'h0);
        chk("t1_latency",   {31'h0, (lat >= 153 && lat <= 155)}, 32'h1);
        settle(CPB);

        // 2: back-to-back frames, no idle gap
        send(8'h00, 1'b1);
        send(8'hFF, 1'b1);
        settle(4);
        chk("t2_valid_cnt", valid_cnt, 3);
        chk("t2_cap0",      {24'h0, cap[1]}, 32'h00);
        chk("t2_cap1",      {24'h0, cap[2]}, 32'hFF);

        // 3: 5-cycle low glitch
        @(negedge clk);
        bus.uart_rxd = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        chk("t3_busy_hi", {31'h0, bus.rx_busy}, 32'h1);
        @(negedge clk);
        bus.uart_rxd = 1'b1;
        repeat (6) @(negedge clk);
        #1;
        chk("t3_busy_lo",   {31'h0, bus.rx_busy}, 32'h0);
        chk("t3_valid_cnt", valid_cnt, 3);
        chk("t3_err_cnt",   err_cnt, 0);

        // 4: framing error followed by a long break
        send(8'h3C, 1'b0);
        repeat (12 * CPB) @(negedge clk);
        #1;
        chk("t4_err_cnt",   err_cnt, 1);
        chk("t4_valid_cnt", valid_cnt, 3);
        chk("t4_data_hold", {24'h0, bus.rx_data}, 32'hFF);
        chk("t4_busy_wait", {31'h0, bus.rx_busy}, 32'h1);
        @(negedge clk);
        bus.uart_rxd = 1'b1;
        settle(4);
        chk("t4_busy_lo",   {31'h0, bus.rx_busy}, 32'h0);
        settle(3 * CPB);
        chk("t4_err_once",  err_cnt, 1);
        chk("t4_no_valid",  valid_cnt, 3);

        // 5: reset during data bit 4 of 0x5A
        b5a = 8'h5A;
        drive_bit(1'b0, CPB);
        for (int i = 0; i < 4; i++) drive_bit(b5a[i], CPB);
        drive_bit(b5a[4], 8);
        reset_n = 1'b0;
        #1;
        chk("t5_rst_data",  {24'h0, bus.rx_data}, 32'h00);
        chk("t5_rst_valid", {31'h0, bus.rx_valid}, 32'h0);
        chk("t5_rst_err",   {31'h0, bus.rx_frame_err}, 32'h0);
        chk("t5_rst_busy",  {31'h0, bus.rx_busy}, 32'h0);
        bus.uart_rxd = 1'b1;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        settle(2 * CPB);
        chk("t5_idle_busy", {31'h0, bus.rx_busy}, 32'h0);
        chk("t5_no_partial", valid_cnt, 3);
        send(8'hC3, 1'b1);
        settle(2);
        chk("t5_valid_cnt", valid_cnt, 4);
        chk("t5_cap",       {24'h0, cap[3]}, 32'hC3);
        chk("t5_data",      {24'h0, bus.rx_data}, 32'hC3);
        settle(CPB);

        // 6: transmitter sum 7 + 9 looped back
        sum = 8'h07 + 8'h09;
        send(sum, 1'b1);
        settle(2);
        chk("t6_data",      {24'h0, bus.rx_data}, 32'h10);
        chk("t6_valid_cnt", valid_cnt, 5);
        chk("t6_err_cnt",   err_cnt, 1);
        chk("never_both",   both_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
